output_port_arbiter: RTL

OUTPUT_PORT_ARBITER -- requirements
Module: output_port_arbiter

---
 rtl/output_port_arbiter_pkg.sv | 28 ++
 rtl/output_port_arbiter_if.sv | 42 ++++
 rtl/output_port_arbiter_rr_pick3.sv | 40 ++++
 rtl/output_port_arbiter.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/output_port_arbiter_pkg.sv
// ============================================================================
// output_port_arbiter_pkg : shared router types, port count and defaults
// Rev 1.0
// ============================================================================
`default_nettype none

package output_port_arbiter_pkg;

  localparam int c_NUM_PORTS  = 3;
  localparam int c_DEF_UWIDTH = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } arb_state_t;

  // Index of a one-hot 3-bit grant; zero maps to index 0.
  function automatic logic [1:0] onehot_to_idx(input logic [c_NUM_PORTS-1:0] oh);
    logic [1:0] idx;
    idx = 2'd0;
    if (oh[1]) idx = 2'd1;
    if (oh[2]) idx = 2'd2;
    return idx;
  endfunction

endpackage

`default_nettype wire

// File: rtl/output_port_arbiter_if.sv
// ============================================================================
// output_port_arbiter_if : source request/data bus and output port bus
// Rev 1.0
// ============================================================================
`default_nettype none

interface output_port_arbiter_if
  import output_port_arbiter_pkg::*;
#(
  parameter int UWIDTH = c_DEF_UWIDTH
);

  logic [c_NUM_PORTS-1:0] req;
  logic [c_NUM_PORTS-1:0] in_valid;
  logic [c_NUM_PORTS-1:0] in_last;
  logic [UWIDTH-1:0]      in_data_1;
  logic [UWIDTH-1:0]      in_data_2;
  logic [UWIDTH-1:0]      in_data_3;
  logic                   out_ready;
  logic [c_NUM_PORTS-1:0] grant;
  logic [c_NUM_PORTS-1:0] pop;
  logic                   out_valid;
  logic                   out_last;
  logic [UWIDTH-1:0]      out_data;
  logic                   busy;
  logic                   timeout_err;

  // Sources and downstream port side.
  modport master (
    output req, in_valid, in_last, in_data_1, in_data_2, in_data_3, out_ready,
    input  grant, pop, out_valid, out_last, out_data, busy, timeout_err
  );

  // Arbiter side.
  modport slave (
    input  req, in_valid, in_last, in_data_1, in_data_2, in_data_3, out_ready,
    output grant, pop, out_valid, out_last, out_data, busy, timeout_err
  );

endinterface

`default_nettype wire

// File: rtl/output_port_arbiter_rr_pick3.sv
// ============================================================================
// rr_pick3 : 3-way round-robin pick, search starts just after rr_ptr_i
// Rev 1.0
// ============================================================================
`default_nettype none

module rr_pick3
  import output_port_arbiter_pkg::*;
(
  input  wire logic [c_NUM_PORTS-1:0] req_i,
  input  wire logic [1:0]             rr_ptr_i,
  output logic      [c_NUM_PORTS-1:0] pick_o
);

  function automatic logic [c_NUM_PORTS-1:0] first_of(
    input logic [c_NUM_PORTS-1:0] r,
    input logic [1:0]             a,
    input logic [1:0]             b,
    input logic [1:0]             c
  );
    logic [c_NUM_PORTS-1:0] oh;
    oh = '0;
    if (r[a])      oh[a] = 1'b1;
    else if (r[b]) oh[b] = 1'b1;
    else if (r[c]) oh[c] = 1'b1;
    return oh;
  endfunction

  always_comb begin
    pick_o = '0;
    case (rr_ptr_i)
      2'd0:    pick_o = first_of(req_i, 2'd1, 2'd2, 2'd0);
      2'd1:    pick_o = first_of(req_i, 2'd2, 2'd0, 2'd1);
      default: pick_o = first_of(req_i, 2'd0, 2'd1, 2'd2);
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/output_port_arbiter.sv
// ============================================================================
// output_port_arbiter : 3-source packet arbiter onto one registered output
// port. Optional packet watchdog enabled by defining ARB_TIMEOUT_EN.
// Rev 1.0
// ============================================================================
`default_nettype none

module output_port_arbiter
  import output_port_arbiter_pkg::*;
#(
  parameter int UWIDTH  = c_DEF_UWIDTH,
  parameter int TIMEOUT = 16,
  parameter int TO_SZ   = 5
)(
  input  wire logic               clk2,
  input  wire logic               rst,
  output_port_arbiter_if.slave    bus
);

  if ((2 ** TO_SZ) <= TIMEOUT) begin : g_bad_to_sz
    $error("TO_SZ too narrow for TIMEOUT");
  end

  arb_state_t             state_q;
  logic [c_NUM_PORTS-1:0] grant_q;
  logic [1:0]             rr_ptr_q;
  logic                   out_valid_q;
  logic                   out_last_q;
  logic [UWIDTH-1:0]      out_data_q;

  logic [c_NUM_PORTS-1:0] w_pick;
  logic [c_NUM_PORTS-1:0] w_pop;
  logic                   w_any_pop;
  logic [UWIDTH-1:0]      w_sel_data;
  logic                   w_sel_last;

  rr_pick3 u_rr_pick3 (
    .req_i    (bus.req),
    .rr_ptr_i (rr_ptr_q),
    .pick_o   (w_pick)
  );

  // A word moves whenever the output register is empty or being drained.
  always_comb begin
    w_pop = '0;
    if (state_q == ST_XFER) begin
      w_pop = grant_q & bus.in_valid & {c_NUM_PORTS{(!out_valid_q || bus.out_ready)}};
    end
  end

  assign w_any_pop = |w_pop;
  assign w_sel_last = |(grant_q & bus.in_last);

  always_comb begin
    w_sel_data = '0;
    case (grant_q)
      3'b001:  w_sel_data = bus.in_data_1;
      3'b010:  w_sel_data = bus.in_data_2;
      3'b100:  w_sel_data = bus.in_data_3;
      default: w_sel_data = '0;
    endcase
  end

`ifdef ARB_TIMEOUT_EN
  logic [TO_SZ-1:0] to_cnt_q;
  logic             to_err_q;
`endif

  always_ff @(posedge clk2 or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      grant_q     <= '0;
      rr_ptr_q    <= 2'd2;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
`ifdef ARB_TIMEOUT_EN
      to_cnt_q    <= '0;
      to_err_q    <= 1'b0;
`endif
    end else begin
`ifdef ARB_TIMEOUT_EN
      to_err_q <= 1'b0;
`endif
      if (w_any_pop) begin
        out_valid_q <= 1'b1;
        out_data_q  <= w_sel_data;
        out_last_q  <= w_sel_last;
      end else if (out_valid_q && bus.out_ready) begin
        out_valid_q <= 1'b0;
      end

      case (state_q)
        ST_IDLE: begin
`ifdef ARB_TIMEOUT_EN
          to_cnt_q <= '0;
`endif
          if (|bus.req) begin
            grant_q <= w_pick;
            state_q <= ST_XFER;
          end
        end

        ST_XFER: begin
          if (w_any_pop && w_sel_last) begin
            rr_ptr_q <= onehot_to_idx(grant_q);
            grant_q  <= '0;
            state_q  <= ST_IDLE;
`ifdef ARB_TIMEOUT_EN
            to_cnt_q <= '0;
`endif
          end
`ifdef ARB_TIMEOUT_EN
          else if (w_any_pop) begin
            to_cnt_q <= '0;
          end else if (to_cnt_q == TO_SZ'(TIMEOUT - 1)) begin
            // This stall cycle brings the count to TIMEOUT: revoke the hung source.
            rr_ptr_q <= onehot_to_idx(grant_q);
            grant_q  <= '0;
            state_q  <= ST_IDLE;
            to_cnt_q <= '0;
            to_err_q <= 1'b1;
          end else begin
            to_cnt_q <= to_cnt_q + 1'b1;
          end
`endif
        end

        default: begin
          state_q <= ST_IDLE;
          grant_q <= '0;
        end
      endcase
    end
  end

  assign bus.grant     = grant_q;
  assign bus.pop       = w_pop;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_data  = out_data_q;
  assign bus.busy      = (state_q == ST_XFER);
`ifdef ARB_TIMEOUT_EN
  assign bus.timeout_err = to_err_q;
`else
  assign bus.timeout_err = 1'b0;
`endif

endmodule

`default_nettype wire
